// File: rtl/uart_flash_pkg.sv
// Shared types and constants for the UART flash command parser.
// Holds the parser state encoding, frame opcodes and response bytes.
package uart_flash_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    ISSUE,
    WAIT_DONE,
    SEND_RESP
  } parser_state_t;

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] ACK_CHAR = 8'h4B;
  localparam logic [7:0] ERR_CHAR = 8'h45;

  function automatic logic is_opcode(input logic [7:0] b);
    return (b == OP_WRITE) || (b == OP_READ);
  endfunction

endpackage

// File: rtl/uart_flash_cmd_parser_timer.sv
// Inter-byte gap timer for frames in progress.
// Ports: clock_input, reset, clear, tick (count enable), expired (count at limit).
module inter_byte_timer #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic clock_input,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  // Count saturates at the limit; the parser leaves the
  // timed states in the same cycle that expired is seen.
  always_ff @(posedge clock_input or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (tick && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/uart_flash_cmd_parser.sv
// Decodes 'W' addr data / 'R' addr UART frames into flash requests.
// Ports: rx byte stream in, flash req/done handshake, tx response byte out, busy, frame_error.
module uart_flash_cmd_parser
  import uart_flash_pkg::*;
#(
  parameter int          ADDR_W         = 8,
  parameter int          TIMEOUT_CYCLES = 50000,
  parameter logic [7:0]  ACK_BYTE       = ACK_CHAR,
  parameter logic [7:0]  ERR_BYTE       = ERR_CHAR
) (
  input  logic              clock_input,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              flash_req,
  output logic              flash_we,
  output logic [ADDR_W-1:0] flash_addr,
  output logic [7:0]        flash_wdata,
  input  logic              flash_done,
  input  logic [7:0]        flash_rdata,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              frame_error
);

  parser_state_t state;
  logic          op_write;
  logic          tmr_tick;
  logic          tmr_clear;
  logic          tmr_expired;

  assign busy = (state != IDLE);

  // Timer runs only while a frame is being collected and
  // restarts on entry (cleared everywhere else) and per byte.
  assign tmr_tick  = (state == GET_ADDR) || (state == GET_DATA);
  assign tmr_clear = !tmr_tick || rx_valid;

  inter_byte_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clock_input(clock_input),
    .reset      (reset),
    .clear      (tmr_clear),
    .tick       (tmr_tick),
    .expired    (tmr_expired)
  );

  always_ff @(posedge clock_input or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      op_write    <= 1'b0;
      flash_req   <= 1'b0;
      flash_we    <= 1'b0;
      flash_addr  <= '0;
      flash_wdata <= '0;
      tx_data     <= '0;
      tx_valid    <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      frame_error <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rx_valid) begin
            if (is_opcode(rx_data)) begin
              op_write <= (rx_data == OP_WRITE);
              state    <= GET_ADDR;
            end else begin
              tx_data  <= ERR_BYTE;
              tx_valid <= 1'b1;
              state    <= SEND_RESP;
            end
          end
        end
        GET_ADDR: begin
          if (rx_valid) begin
            flash_addr <= ADDR_W'(rx_data);
            state      <= op_write ? GET_DATA : ISSUE;
          end else if (tmr_expired) begin
            frame_error <= 1'b1;
            state       <= IDLE;
          end
        end
        GET_DATA: begin
          if (rx_valid) begin
            flash_wdata <= rx_data;
            state       <= ISSUE;
          end else if (tmr_expired) begin
            frame_error <= 1'b1;
            state       <= IDLE;
          end
        end
        ISSUE: begin
          frame_error <= rx_valid;
          flash_req   <= 1'b1;
          flash_we    <= op_write;
          state       <= WAIT_DONE;
        end
        WAIT_DONE: begin
          frame_error <= rx_valid;
          if (flash_done && flash_req) begin
            flash_req <= 1'b0;
            tx_data   <= op_write ? ACK_BYTE : flash_rdata;
            tx_valid  <= 1'b1;
            state     <= SEND_RESP;
          end
        end
        SEND_RESP: begin
          // A byte landing on the handshake cycle is still dropped;
          // IDLE only listens from the following cycle.
          frame_error <= rx_valid;
          if (tx_ready) begin
            tx_valid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_flash_cmd_parser.sv
// Self-checking bench for uart_flash_cmd_parser.
// Frame-level model plus directed vectors with literal expectations.
module tb_uart_flash_cmd_parser;

  localparam int TO = 20;

  logic       clock_input = 1'b0;
  logic       reset       = 1'b1;
  logic [7:0] rx_data     = 8'h00;
  logic       rx_valid    = 1'b0;
  logic       flash_done  = 1'b0;
  logic [7:0] flash_rdata = 8'h00;
  logic       tx_ready    = 1'b0;
  logic       flash_req;
  logic       flash_we;
  logic [7:0] flash_addr;
  logic [7:0] flash_wdata;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       busy;
  logic       frame_error;

  uart_flash_cmd_parser #(
    .ADDR_W        (8),
    .TIMEOUT_CYCLES(TO),
    .ACK_BYTE      (8'h4B),
    .ERR_BYTE      (8'h45)
  ) dut (
    .clock_input(clock_input),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .flash_req  (flash_req),
    .flash_we   (flash_we),
    .flash_addr (flash_addr),
    .flash_wdata(flash_wdata),
    .flash_done (flash_done),
    .flash_rdata(flash_rdata),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .frame_error(frame_error)
  );

  always #5 clock_input = ~clock_input;

  int n_checks   = 0;
  int n_fail     = 0;
  int ferr_count = 0;
  bit chk_en     = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Frame-level model: bytes of the current frame in a queue,
  // inter-byte gap as a plain integer, and the response owed.
  logic [7:0] q[$];
  int         gap;
  bit         collecting, issue_pend;
  bit         m_req, m_we, m_txv, m_ferr;
  logic [7:0] m_addr, m_wdata, m_txd;

  always @(posedge clock_input or posedge reset) begin
    if (reset) begin
      q.delete();
      gap = 0; collecting = 0; issue_pend = 0;
      m_req = 0; m_we = 0; m_txv = 0; m_ferr = 0;
      m_addr = 0; m_wdata = 0; m_txd = 0;
    end else begin
      m_ferr = 0;
      if (collecting) begin
        if (rx_valid) begin
          q.push_back(rx_data);
          gap = 0;
          if (q.size() == 2) m_addr = rx_data;
          else m_wdata = rx_data;
          if (q.size() == ((q[0] == 8'h57) ? 3 : 2)) begin
            collecting = 0;
            issue_pend = 1;
          end
        end else if (gap == TO - 1) begin
          m_ferr = 1;
          collecting = 0;
          q.delete();
        end else begin
          gap++;
        end
      end else if (issue_pend || m_req || m_txv) begin
        if (rx_valid) m_ferr = 1;
        if (issue_pend) begin
          issue_pend = 0;
          m_req = 1;
          m_we = (q[0] == 8'h57);
        end else if (m_req) begin
          if (flash_done) begin
            m_req = 0;
            m_txv = 1;
            m_txd = m_we ? 8'h4B : flash_rdata;
          end
        end else if (tx_ready) begin
          m_txv = 0;
        end
      end else if (rx_valid) begin
        if (rx_data == 8'h57 || rx_data == 8'h52) begin
          q.delete();
          q.push_back(rx_data);
          collecting = 1;
          gap = 0;
        end else begin
          m_txv = 1;
          m_txd = 8'h45;
        end
      end
    end
  end

  always @(negedge clock_input) begin
    if (chk_en && !reset) begin
      chk("m_req",   32'(flash_req),   32'(m_req));
      chk("m_we",    32'(flash_we),    32'(m_we));
      chk("m_addr",  32'(flash_addr),  32'(m_addr));
      chk("m_wdata", 32'(flash_wdata), 32'(m_wdata));
      chk("m_txv",   32'(tx_valid),    32'(m_txv));
      chk("m_ferr",  32'(frame_error), 32'(m_ferr));
      chk("m_busy",  32'(busy),
          32'(collecting | issue_pend | m_req | m_txv));
      if (m_txv) chk("m_txd", 32'(tx_data), 32'(m_txd));
      if (frame_error) ferr_count++;
    end
  end

  task automatic cyc();
    @(posedge clock_input);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    cyc();
    rx_valid = 1'b0;
  endtask

  task automatic wait_req();
    int k = 0;
    while (!flash_req && k < 50) begin
      cyc();
      k++;
    end
    chk("req_seen", 32'(flash_req), 1);
  endtask

  task automatic done(input logic [7:0] rd);
    repeat (4) cyc();
    flash_done  = 1'b1;
    flash_rdata = rd;
    cyc();
    flash_done  = 1'b0;
  endtask

  task automatic resp(input logic [7:0] exp);
    int k = 0;
    while (!tx_valid && k < 50) begin
      cyc();
      k++;
    end
    chk("tx_valid_up", 32'(tx_valid), 1);
    chk("tx_data", 32'(tx_data), 32'(exp));
    repeat (2) cyc();
    chk("tx_held", 32'(tx_valid), 1);
    tx_ready = 1'b1;
    cyc();
    tx_ready = 1'b0;
    chk("tx_drop", 32'(tx_valid), 0);
    chk("idle_after", 32'(busy), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int f0;
    int first;
    repeat (3) cyc();
    chk("rst_req",   32'(flash_req),   0);
    chk("rst_busy",  32'(busy),        0);
    chk("rst_txv",   32'(tx_valid),    0);
    chk("rst_ferr",  32'(frame_error), 0);
    chk("rst_addr",  32'(flash_addr),  0);
    chk("rst_txd",   32'(tx_data),     0);
    reset  = 1'b0;
    chk_en = 1'b1;
    cyc();

    // write frame
    send(8'h57); send(8'h10); send(8'hA5);
    chk("wr_busy", 32'(busy), 1);
    chk("wr_noreq", 32'(flash_req), 0);
    cyc();
    chk("wr_req_1cyc", 32'(flash_req), 1);
    wait_req();
    chk("wr_we",    32'(flash_we),    1);
    chk("wr_addr",  32'(flash_addr),  32'h10);
    chk("wr_wdata", 32'(flash_wdata), 32'hA5);
    done(8'h00);
    resp(8'h4B);

    // read frame
    send(8'h52); send(8'h3C);
    wait_req();
    chk("rd_we",   32'(flash_we),   0);
    chk("rd_addr", 32'(flash_addr), 32'h3C);
    done(8'h7E);
    resp(8'h7E);

    // unknown opcode, then a byte on the handshake cycle
    send(8'h41);
    chk("unk_txv", 32'(tx_valid), 1);
    chk("unk_txd", 32'(tx_data),  32'h45);
    chk("unk_req", 32'(flash_req), 0);
    tx_ready = 1'b1;
    send(8'h52);
    tx_ready = 1'b0;
    chk("hs_drop_ferr", 32'(frame_error), 1);
    chk("hs_drop_busy", 32'(busy), 0);
    chk("hs_drop_txv",  32'(tx_valid), 0);
    cyc();

    // timeout
    f0 = ferr_count;
    send(8'h57); send(8'h10);
    first = 0;
    for (int i = 1; i <= 30; i++) begin
      cyc();
      if (frame_error && first == 0) first = i;
    end
    chk("to_cycle", 32'(first), 20);
    chk("to_idle",  32'(busy), 0);
    chk("to_once",  32'(ferr_count - f0), 1);

    // last byte just inside the timeout window
    f0 = ferr_count;
    send(8'h57); send(8'h10);
    repeat (18) cyc();
    send(8'hC3);
    chk("to_edge_noerr", 32'(ferr_count - f0), 0);
    wait_req();
    chk("to_edge_wdata", 32'(flash_wdata), 32'hC3);
    done(8'h00);
    resp(8'h4B);

    // overrun while waiting for flash
    send(8'h57); send(8'h22); send(8'h33);
    wait_req();
    cyc();
    f0 = ferr_count;
    send(8'h99);
    chk("ovr_pulse", 32'(frame_error), 1);
    cyc();
    chk("ovr_pulse_end", 32'(frame_error), 0);
    chk("ovr_addr",  32'(flash_addr),  32'h22);
    chk("ovr_wdata", 32'(flash_wdata), 32'h33);
    chk("ovr_req",   32'(flash_req),   1);
    chk("ovr_once",  32'(ferr_count - f0), 1);
    done(8'h00);
    resp(8'h4B);

    // highest address
    send(8'h52); send(8'hFF);
    wait_req();
    chk("ff_addr", 32'(flash_addr), 32'hFF);
    done(8'h5A);
    resp(8'h5A);

    // reset mid-WAIT_DONE
    send(8'h52); send(8'h44);
    wait_req();
    cyc();
    reset = 1'b1;
    #1;
    chk("mid_rst_req",  32'(flash_req), 0);
    chk("mid_rst_txv",  32'(tx_valid),  0);
    chk("mid_rst_busy", 32'(busy),      0);
    repeat (2) cyc();
    reset = 1'b0;
    cyc();
    send(8'h52); send(8'h81);
    wait_req();
    chk("post_rst_addr", 32'(flash_addr), 32'h81);
    chk("post_rst_we",   32'(flash_we),   0);
    done(8'h19);
    resp(8'h19);

    repeat (3) cyc();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
